wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 30 +++
 rtl/wb_stage_load_align.sv | 38 +++
 rtl/wb_stage.sv | 114 +++++++++++
 tb/tb_wb_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared CPU package: datapath width, load-type and WB state encodings,
// and the latched instruction bundle held by the writeback stage.
package wb_stage_pkg;

  localparam int CPU_XLEN = 32;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5
  } load_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    logic [CPU_XLEN-1:0] inst;
    logic [4:0]          wreg_index;
    logic                wreg_en;
    logic [2:0]          load_type;
    logic [CPU_XLEN-1:0] data;
  } wb_latch_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks byte/halfword/word from an aligned
// response word and sign- or zero-extends it.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [CPU_XLEN-1:0] word,
  input  logic [1:0]          off,
  input  logic [2:0]          load_type,
  output logic [CPU_XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        is_lb;
  logic        is_lh;
  logic        is_lbu;
  logic        is_lhu;

  assign b      = 8'(word >> {off, 3'b000});
  assign h      = off[1] ? word[31:16] : word[15:0];
  assign is_lb  = load_type == LT_LB;
  assign is_lh  = load_type == LT_LH;
  assign is_lbu = load_type == LT_LBU;
  assign is_lhu = load_type == LT_LHU;

  // LW and every undefined encoding return the full word
  always_comb begin
    data = word;
    unique case (1'b1)
      is_lb:   data = {{24{b[7]}}, b};
      is_lh:   data = {{16{h[15]}}, h};
      is_lbu:  data = {24'd0, b};
      is_lhu:  data = {16'd0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions, waits for load responses,
// writes the register file and drives the forwarding entry.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int          XLEN        = CPU_XLEN,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            left_valid,
  output logic            left_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  input  logic [4:0]      in_wreg_index,
  input  logic            in_wreg_en,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_is_load,
  input  logic [2:0]      in_load_type,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [XLEN-1:0] commit_inst,
  output logic            fwd_valid,
  output logic [4:0]      fwd_index,
  output logic [XLEN-1:0] fwd_data,
  output logic            rsp_err
);

  localparam int CW = $clog2(RSP_TIMEOUT + 1);

  wb_state_e       state;
  wb_state_e       state_nx;
  wb_latch_t       lat;
  logic [CW-1:0]   wait_cnt;
  logic            err;
  logic            accept;
  logic            timeout;
  logic            wr_ok;
  logic [XLEN-1:0] ld_data;

  assign left_ready = (state == ST_EMPTY) | (state == ST_DONE);
  assign accept     = left_valid & left_ready;
  // A response in the last allowed cycle still wins over the timeout
  assign timeout    = (state == ST_WAIT) & ~dmem_rsp_valid &
                      (wait_cnt == CW'(RSP_TIMEOUT - 1));

  load_align u_load_align (
    .word      (dmem_rsp_data),
    .off       (lat.data[1:0]),
    .load_type (lat.load_type),
    .data      (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_EMPTY,
      ST_DONE: begin
        if (accept) state_nx = in_is_load ? ST_WAIT : ST_DONE;
        else        state_nx = ST_EMPTY;
      end
      ST_WAIT: begin
        if (dmem_rsp_valid || timeout) state_nx = ST_DONE;
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat      <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        lat.pc         <= in_pc;
        lat.inst       <= in_inst;
        lat.wreg_index <= in_wreg_index;
        lat.wreg_en    <= in_wreg_en;
        lat.load_type  <= in_load_type;
        lat.data       <= in_result;
      end else if (state == ST_WAIT) begin
        if (dmem_rsp_valid) lat.data <= ld_data;
        else if (timeout)   lat.data <= '0;
      end
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                  wait_cnt <= '0;
      if ((dmem_rsp_valid && state != ST_WAIT) || timeout) err <= 1'b1;
    end
  end

  assign wr_ok        = lat.wreg_en & (lat.wreg_index != 5'd0);
  assign commit_valid = state == ST_DONE;
  assign commit_pc    = lat.pc;
  assign commit_inst  = lat.inst;
  assign rf_we        = commit_valid & wr_ok;
  assign rf_waddr     = lat.wreg_index;
  assign rf_wdata     = lat.data;
  assign fwd_valid    = commit_valid & wr_ok;
  assign fwd_index    = lat.wreg_index;
  assign fwd_data     = lat.data;
  assign rsp_err      = err;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: per-feature tasks with inline
// checks against hand-computed expected values.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        left_valid;
  logic        left_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  in_wreg_index;
  logic        in_wreg_en;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        fwd_valid;
  logic [4:0]  fwd_index;
  logic [31:0] fwd_data;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk            (clk),
    .reset          (reset),
    .left_valid     (left_valid),
    .left_ready     (left_ready),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_wreg_index  (in_wreg_index),
    .in_wreg_en     (in_wreg_en),
    .in_result      (in_result),
    .in_is_load     (in_is_load),
    .in_load_type   (in_load_type),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_data  (dmem_rsp_data),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_inst    (commit_inst),
    .fwd_valid      (fwd_valid),
    .fwd_index      (fwd_index),
    .fwd_data       (fwd_data),
    .rsp_err        (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(input logic [31:0] pc, input logic [4:0] idx,
                          input logic en, input logic [31:0] res);
    left_valid    = 1'b1;
    in_pc         = pc;
    in_inst       = 32'h0000_0033;
    in_wreg_index = idx;
    in_wreg_en    = en;
    in_result     = res;
    in_is_load    = 1'b0;
    in_load_type  = 3'd0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // dly = WAIT cycle in which the response is driven; 0 = never respond
  task automatic run_load(input logic [31:0] addr, input logic [2:0] lt,
                          input logic [31:0] rsp, input int dly,
                          output logic [31:0] wd, output logic we,
                          output int waits, output bit done,
                          output bit fwd_seen);
    wd = '0;
    we = 1'b0;
    waits = 0;
    done = 1'b0;
    fwd_seen = 1'b0;
    left_valid    = 1'b1;
    in_pc         = 32'h0000_0400;
    in_inst       = 32'h0000_0003;
    in_wreg_index = 5'd7;
    in_wreg_en    = 1'b1;
    in_result     = addr;
    in_is_load    = 1'b1;
    in_load_type  = lt;
    @(negedge clk);
    left_valid = 1'b0;
    in_is_load = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      dmem_rsp_valid = 1'b0;
      if (commit_valid) begin
        done = 1'b1;
        wd   = rf_wdata;
        we   = rf_we;
      end else begin
        if (!left_ready) waits++;
        if (fwd_valid === 1'b1) fwd_seen = 1'b1;
        if (dly != 0 && waits == dly) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_data  = rsp;
        end
        @(negedge clk);
      end
    end
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    left_valid = 1'b0;
    in_pc = '0;
    in_inst = '0;
    in_wreg_index = '0;
    in_wreg_en = 1'b0;
    in_result = '0;
    in_is_load = 1'b0;
    in_load_type = '0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (left_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", left_ready);
    end
    checks++;
    if ({commit_valid, rf_we, fwd_valid, rsp_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {commit_valid, rf_we, fwd_valid, rsp_err});
    end
    checks++;
    if ({rf_waddr, rf_wdata, commit_pc, commit_inst} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0", rf_waddr, rf_wdata,
               commit_pc);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    drive_op(32'h0000_0100, 5'd5, 1'b1, 32'h0000_1234);
    @(negedge clk);
    left_valid = 1'b0;
    checks++;
    if ({commit_valid, rf_we} !== 2'b11) begin
      errors++;
      $display("FAIL add_commit got %b want 11", {commit_valid, rf_we});
    end
    checks++;
    if (rf_waddr !== 5'd5 || rf_wdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL add_write got %0d/%h want 5/00001234", rf_waddr,
               rf_wdata);
    end
    checks++;
    if (commit_pc !== 32'h0000_0100) begin
      errors++;
      $display("FAIL add_pc got %h want 00000100", commit_pc);
    end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_index !== 5'd5 ||
        fwd_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL add_fwd got %b/%0d/%h want 1/5/00001234", fwd_valid,
               fwd_index, fwd_data);
    end
    @(negedge clk);
    checks++;
    if (commit_valid !== 1'b0 || left_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_idle got %b/%b want 0/1", commit_valid,
               left_ready);
    end
  endtask

  task automatic test_lb();
    logic [31:0] wd;
    logic        we;
    int          waits;
    bit          done;
    bit          fw;
    run_load(32'h0000_1003, 3'd0, 32'h80FF_FF00, 3, wd, we, waits, done, fw);
    checks++;
    if (!done || waits != 3) begin
      errors++;
      $display("FAIL lb_wait got done=%0d waits=%0d want 1/3", done, waits);
    end
    checks++;
    if (wd !== 32'hFFFF_FF80 || we !== 1'b1) begin
      errors++;
      $display("FAIL lb_data got %h/%b want ffffff80/1", wd, we);
    end
    checks++;
    if (fw) begin
      errors++;
      $display("FAIL lb_fwd_in_wait got 1 want 0");
    end
    @(negedge clk);
  endtask

  task automatic test_load_types();
    logic [31:0] addr [6] = '{32'h2002, 32'h2002, 32'h2001, 32'h2001,
                              32'h2001, 32'h2000};
    logic [2:0]  lt   [6] = '{3'd5, 3'd1, 3'd4, 3'd2, 3'd3, 3'd0};
    logic [31:0] rsp  [6] = '{32'hBEEF_0000, 32'hBEEF_0000, 32'h1234_A5C3,
                              32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_007F};
    logic [31:0] exp  [6] = '{32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_00A5,
                              32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_007F};
    logic [31:0] wd;
    logic        we;
    int          waits;
    bit          done;
    bit          fw;
    for (int i = 0; i < 6; i++) begin
      run_load(addr[i], lt[i], rsp[i], 1, wd, we, waits, done, fw);
      checks++;
      if (!done || wd !== exp[i]) begin
        errors++;
        $display("FAIL load_type_%0d got %h want %h", i, wd, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res [3] = '{32'h11, 32'h22, 32'h33};
    drive_op(32'h200, 5'd1, 1'b1, res[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (commit_valid !== 1'b1 || left_ready !== 1'b1 ||
          rf_wdata !== res[k] || rf_waddr !== 5'(k + 1)) begin
        errors++;
        $display("FAIL b2b_%0d got %b/%b/%h/%0d want 1/1/%h/%0d", k,
                 commit_valid, left_ready, rf_wdata, rf_waddr, res[k], k + 1);
      end
      if (k < 2) drive_op(32'h204 + 32'(4 * k), 5'(k + 2), 1'b1, res[k+1]);
      else       left_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    drive_op(32'h300, 5'd0, 1'b1, 32'h0000_FFFF);
    @(negedge clk);
    left_valid = 1'b0;
    checks++;
    if ({commit_valid, rf_we, fwd_valid} !== 3'b100) begin
      errors++;
      $display("FAIL x0_write got %b want 100",
               {commit_valid, rf_we, fwd_valid});
    end
    @(negedge clk);
  endtask

  task automatic test_rsp_in_empty();
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    checks++;
    if ({rsp_err, rf_we, commit_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rsp_empty got %b want 100",
               {rsp_err, rf_we, commit_valid});
    end
  endtask

  task automatic test_reset_in_wait();
    pulse_reset();
    checks++;
    if (rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_clear_err got %b want 0", rsp_err);
    end
    left_valid    = 1'b1;
    in_is_load    = 1'b1;
    in_load_type  = 3'd2;
    in_wreg_index = 5'd9;
    in_wreg_en    = 1'b1;
    in_result     = 32'h4000;
    @(negedge clk);
    left_valid = 1'b0;
    in_is_load = 1'b0;
    checks++;
    if (left_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_ready got %b want 0", left_ready);
    end
    pulse_reset();
    checks++;
    if (left_ready !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wait got %b/%b want 1/0", left_ready, rsp_err);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rsp_data  = 32'h1111_2222;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    checks++;
    if (rsp_err !== 1'b1 || commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rsp got %b/%b want 1/0", rsp_err,
               commit_valid);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] wd;
    logic        we;
    int          waits;
    bit          done;
    bit          fw;
    pulse_reset();
    run_load(32'h0000_3000, 3'd2, 32'h0, 0, wd, we, waits, done, fw);
    checks++;
    if (!done || waits != 255) begin
      errors++;
      $display("FAIL timeout_wait got done=%0d waits=%0d want 1/255", done,
               waits);
    end
    checks++;
    if (wd !== 32'h0 || we !== 1'b1) begin
      errors++;
      $display("FAIL timeout_data got %h/%b want 00000000/1", wd, we);
    end
    checks++;
    if (rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got %b want 1", rsp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb();
    test_load_types();
    test_back_to_back();
    test_x0();
    test_rsp_in_empty();
    test_reset_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
